pc_fetch_unit: RTL and testbench

Parametrised program-counter and fetch-request unit for the F stage of the pipelined MIPS core. It replaces the bare PC register with:
- a valid/ack fetch handshake toward instruction memory;
- prioritised redirects: exception, eret, jr, branch;
- a pending-redirect buffer for redirects that arrive while a fetch is outstanding;
- misaligned-fetch detection.

It sits between the D-stage redirect logic / CP0 and the instruction memory port.

---
 rtl/pc_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: F-stage program counter and fetch-request unit with prioritised redirects (Exc > Eret > Jr > Br > seq).
// Latency: PC updates on the rising edge after a transfer or redirect; IReq/InstrValid_F/AdEL_F are combinational from state.
// Backpressure: IReq holds with stable IAddr until IAck; redirects arriving under an un-acked request are buffered until IAck.
//
// Ports:
//   clk, Reset                 - clock, synchronous active-high reset
//   Stall_F                    - hazard-unit stall; blocks requests and Jr/Br redirects
//   Exc, Eret, EpcData         - CP0 exception / return-from-exception redirects (honoured under stall)
//   Jr_D, JrData_D             - jr/jalr redirect from D
//   Br_D, BrTarget_D           - taken branch / j / jal redirect from D
//   IReq, IAddr, IAck          - instruction memory request handshake
//   pc, pc_plus_inc            - current F-stage PC and its sequential successor
//   InstrValid_F               - instruction returned this cycle may enter D
//   AdEL_F                     - misaligned PC fetch fault
module pc_fetch_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int unsigned      INC       = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Stall_F,
    input  logic             Exc,
    input  logic             Eret,
    input  logic [WIDTH-1:0] EpcData,
    input  logic             Jr_D,
    input  logic [WIDTH-1:0] JrData_D,
    input  logic             Br_D,
    input  logic [WIDTH-1:0] BrTarget_D,
    output logic             IReq,
    output logic [WIDTH-1:0] IAddr,
    input  logic             IAck,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             InstrValid_F,
    output logic             AdEL_F
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PEND  = 2'd2
    } state_e;

    // Larger value wins; R_NONE means sequential flow.
    typedef enum logic [2:0] {
        R_NONE = 3'd0,
        R_BR   = 3'd1,
        R_JR   = 3'd2,
        R_ERET = 3'd3,
        R_EXC  = 3'd4
    } rank_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    rank_e            pend_rank_q, pend_rank_d;

    rank_e            rd_rank;
    logic [WIDTH-1:0] rd_tgt;
    logic             rd_any;
    logic             adel;
    logic             xfer;
    logic             req_stuck;
    logic             pend_take;
    logic [WIDTH-1:0] pend_tgt_eff;
    rank_e            pend_rank_eff;

    assign adel         = (pc_q[1:0] != 2'b00);
    assign pc           = pc_q;
    assign IAddr        = pc_q;
    assign pc_plus_inc  = pc_q + INC_W;
    assign AdEL_F       = adel;

    // Redirect arbitration. D-stage redirects are dropped under stall (D will
    // re-present them) and while the PC is faulting (only CP0 can recover).
    always_comb begin
        rd_rank = R_NONE;
        rd_tgt  = '0;
        if (Exc) begin
            rd_rank = R_EXC;
            rd_tgt  = EXC_VEC;
        end else if (Eret) begin
            rd_rank = R_ERET;
            rd_tgt  = EpcData;
        end else if (Jr_D && !Stall_F && !adel) begin
            rd_rank = R_JR;
            rd_tgt  = JrData_D;
        end else if (Br_D && !Stall_F && !adel) begin
            rd_rank = R_BR;
            rd_tgt  = BrTarget_D;
        end
    end

    assign rd_any    = (rd_rank != R_NONE);
    assign xfer      = IReq & IAck;
    assign req_stuck = IReq & ~IAck;

    // A buffered redirect is replaced only by one of equal or higher priority;
    // the replacement is visible in the same cycle so an Exc coincident with
    // IAck still wins.
    assign pend_take     = rd_any && (rd_rank >= pend_rank_q);
    assign pend_tgt_eff  = pend_take ? rd_tgt  : pend_tgt_q;
    assign pend_rank_eff = pend_take ? rd_rank : pend_rank_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (rd_any && req_stuck) state_d = S_PEND;
            S_PEND:  if (IAck) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        IReq         = 1'b0;
        InstrValid_F = 1'b0;
        case (state_q)
            S_FETCH: begin
                IReq         = ~Stall_F & ~adel;
                // An instruction acked alongside a winning redirect is wrong-path.
                InstrValid_F = IReq & IAck & ~rd_any;
            end
            S_PEND:  IReq = 1'b1;
            default: IReq = 1'b0;
        endcase
    end

    // Datapath next state: pc only moves when no request is left un-acked.
    always_comb begin
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        pend_rank_d = pend_rank_q;
        case (state_q)
            S_PEND: begin
                pend_tgt_d  = pend_tgt_eff;
                pend_rank_d = pend_rank_eff;
                if (IAck) begin
                    pc_d        = pend_tgt_eff;
                    pend_rank_d = R_NONE;
                end
            end
            default: begin
                if (rd_any) begin
                    if (req_stuck) begin
                        pend_tgt_d  = rd_tgt;
                        pend_rank_d = rd_rank;
                    end else begin
                        pc_d = rd_tgt;
                    end
                end else if (xfer) begin
                    pc_d = pc_plus_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q        <= RESET_VEC;
            pend_tgt_q  <= '0;
            pend_rank_q <= R_NONE;
        end else begin
            pc_q        <= pc_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_rank_q <= pend_rank_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized + directed bench for pc_fetch_unit with a scoreboard.
// Each driven cycle pushes the expected observable response; a monitor pops and compares on the falling edge.
// The reference model tracks architectural PC, an outstanding-redirect buffer and a started flag.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_V = 32'h0000_3000;
    localparam logic [31:0] EXC_V = 32'h0000_4180;

    logic        clk;
    logic        Reset;
    logic        Stall_F;
    logic        Exc;
    logic        Eret;
    logic [31:0] EpcData;
    logic        Jr_D;
    logic [31:0] JrData_D;
    logic        Br_D;
    logic [31:0] BrTarget_D;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        InstrValid_F;
    logic        AdEL_F;

    pc_fetch_unit #(
        .WIDTH     (32),
        .RESET_VEC (RST_V),
        .EXC_VEC   (EXC_V),
        .INC       (4)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Stall_F      (Stall_F),
        .Exc          (Exc),
        .Eret         (Eret),
        .EpcData      (EpcData),
        .Jr_D         (Jr_D),
        .JrData_D     (JrData_D),
        .Br_D         (Br_D),
        .BrTarget_D   (BrTarget_D),
        .IReq         (IReq),
        .IAddr        (IAddr),
        .IAck         (IAck),
        .pc           (pc),
        .pc_plus_inc  (pc_plus_inc),
        .InstrValid_F (InstrValid_F),
        .AdEL_F       (AdEL_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ireq;
        logic [31:0] addr;
        logic [31:0] ppi;
        bit          ivalid;
        bit          adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    bit          m_started;
    bit          m_pending;
    logic [31:0] m_pc;
    logic [31:0] m_ptgt;
    int          m_prank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ireq", {31'b0, IReq}, {31'b0, e.ireq});
                chk("pc", pc, e.addr);
                chk("iaddr", IAddr, e.addr);
                chk("pc_plus_inc", pc_plus_inc, e.ppi);
                chk("adel", {31'b0, AdEL_F}, {31'b0, e.adel});
                chk("instr_valid", {31'b0, InstrValid_F}, {31'b0, e.ivalid});
            end
        end
    end

    // Drive one cycle, predict its response, advance the model, then move to the next cycle.
    task automatic step(input bit rst, input bit st, input bit ex, input bit er, input bit jr,
                        input bit br, input logic [31:0] epc, input logic [31:0] jt,
                        input logic [31:0] bt, input bit ack);
        exp_t        e;
        int          rank;
        logic [31:0] tgt;
        bit          adel, ireq, xfer;
        Reset = rst; Stall_F = st; Exc = ex; Eret = er; Jr_D = jr; Br_D = br;
        EpcData = epc; JrData_D = jt; BrTarget_D = bt; IAck = ack;

        adel = (m_pc[1:0] != 2'b00);
        ireq = m_started && (m_pending || (!st && !adel));
        xfer = ireq && ack;
        rank = 0; tgt = '0;
        if (ex)                       begin rank = 4; tgt = EXC_V; end
        else if (er)                  begin rank = 3; tgt = epc;   end
        else if (jr && !st && !adel)  begin rank = 2; tgt = jt;    end
        else if (br && !st && !adel)  begin rank = 1; tgt = bt;    end

        e.ireq   = ireq;
        e.addr   = m_pc;
        e.ppi    = m_pc + 32'd4;
        e.adel   = adel;
        e.ivalid = xfer && !m_pending && (rank == 0);
        exp_q.push_back(e);

        if (rst) begin
            m_started = 0; m_pending = 0; m_pc = RST_V; m_prank = 0;
        end else if (m_pending) begin
            if (rank != 0 && rank >= m_prank) begin m_ptgt = tgt; m_prank = rank; end
            if (ack) begin m_pc = m_ptgt; m_pending = 0; m_prank = 0; end
        end else begin
            if (rank != 0) begin
                if (ireq && !ack) begin m_pending = 1; m_ptgt = tgt; m_prank = rank; end
                else m_pc = tgt;
            end else if (xfer) begin
                m_pc = m_pc + 32'd4;
            end
            m_started = 1;
        end

        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 31) == 0) t = 32'hFFFF_FFFC;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1; Stall_F = 0; Exc = 0; Eret = 0; Jr_D = 0; Br_D = 0;
        EpcData = '0; JrData_D = '0; BrTarget_D = '0; IAck = 1;
        @(posedge clk);
        #1;
        m_started = 0; m_pending = 0; m_pc = RST_V; m_ptgt = '0; m_prank = 0;

        // Reset second cycle, then sequential fetch 0x3000, 0x3004
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Stall with branch present: ignored, pc holds 0x3008
        repeat (3) step(0, 1, 0, 0, 0, 1, 0, 0, 32'h3100, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Un-acked request with jr: buffered, then killed on ack
        step(0, 0, 0, 0, 1, 0, 0, 32'h3200, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Exc beats jr/br under stall
        step(0, 1, 1, 0, 1, 1, 0, 32'h3300, 32'h3400, 1);
        // Exc overrides a buffered branch, then coincident with ack
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h5000, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h5000, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        // Eret to misaligned address, stuck until Exc
        step(0, 0, 0, 1, 0, 0, 32'h3002, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h3100, 1);
        step(0, 0, 0, 0, 1, 0, 0, 32'h3200, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Wrap at top of address space
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Reset mid-PEND drops the buffered target
        step(0, 0, 0, 0, 1, 0, 0, 32'h3600, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0,
                 rnd_tgt(), rnd_tgt(), rnd_tgt(),
                 $urandom_range(0, 9) < 6);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
